// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub operand path: opcode encoding and the
// operand bundle handed to the ripple-carry adder/subtractor.
package addsub_pkg;

    localparam int OP_WIDTH = 3;
    localparam int ADDSUB_WORD_WIDTH = 36;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_ADD   = 3'd0,  // A + B
        OP_SUB   = 3'd1,  // A - B
        OP_RSUB  = 3'd2,  // B - A
        OP_NADD  = 3'd3,  // -A - B
        OP_PASSA = 3'd4,  // A
        OP_NEGA  = 3'd5   // -A
    } addsub_op_e;

    // Operand bundle at the default datapath width. Modules built at another
    // width declare a local struct with this exact field order, so the packed
    // layout stays compatible with the adder wrapper.
    typedef struct packed {
        logic [ADDSUB_WORD_WIDTH-1:0] a;
        logic                         a_neg;
        logic [ADDSUB_WORD_WIDTH-1:0] b;
        logic                         b_neg;
        logic                         illegal;
    } operand_bundle_t;

    // Packed width of an operand bundle for a given word width.
    function automatic int bundle_width(input int word_width);
        return 2 * word_width + 3;
    endfunction

endpackage

// File: rtl/skid_buffer_2entry.sv
// Generic two-register valid/ready skid buffer. in_ready is registered, so
// there is no combinational path from out_ready back upstream; the skid
// register absorbs the one transfer that lands while the output stalls.
module skid_buffer_2entry #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,  // neither register valid
        BUSY  = 2'd1,  // output register valid only
        FULL  = 2'd2   // output and skid registers valid
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             drain;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Occupancy FSM; out_valid and in_ready are registered alongside state.
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (drain && accept) begin
                        out_data <= in_data;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end else if (accept) begin
                        // Output stalled: park the new op behind it.
                        skid_data <= in_data;
                        in_ready  <= 1'b0;
                        state     <= FULL;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain) begin
                        out_data <= skid_data;
                        in_ready <= 1'b1;
                        state    <= BUSY;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/addsub_operand_stage.sv
// Operand stage in front of the add/sub unit: decodes the opcode into
// {A, A_negative, B, B_negative} and registers it through a 2-entry skid
// buffer so the adder always sees stable, registered operands.
module addsub_operand_stage
    import addsub_pkg::*;
#(
    parameter int WORD_WIDTH = 36
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   in_op,
    input  logic [WORD_WIDTH-1:0] in_a,
    input  logic [WORD_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_a,
    output logic                  out_a_negative,
    output logic [WORD_WIDTH-1:0] out_b,
    output logic                  out_b_negative,
    output logic                  out_illegal
);

    // Same field order as addsub_pkg::operand_bundle_t, at this width.
    typedef struct packed {
        logic [WORD_WIDTH-1:0] a;
        logic                  a_neg;
        logic [WORD_WIDTH-1:0] b;
        logic                  b_neg;
        logic                  illegal;
    } bundle_t;

    localparam int BUNDLE_W = $bits(bundle_t);

    bundle_t decoded;
    bundle_t presented;

    // Opcode decode; undefined opcodes zero every operand so the adder sums 0.
    always_comb begin
        decoded = '0;
        case (in_op)
            OP_ADD: begin
                decoded.a = in_a;
                decoded.b = in_b;
            end
            OP_SUB: begin
                decoded.a     = in_a;
                decoded.b     = in_b;
                decoded.b_neg = 1'b1;
            end
            OP_RSUB: begin
                decoded.a     = in_a;
                decoded.a_neg = 1'b1;
                decoded.b     = in_b;
            end
            OP_NADD: begin
                decoded.a     = in_a;
                decoded.a_neg = 1'b1;
                decoded.b     = in_b;
                decoded.b_neg = 1'b1;
            end
            OP_PASSA: begin
                decoded.a = in_a;
            end
            OP_NEGA: begin
                decoded.a     = in_a;
                decoded.a_neg = 1'b1;
            end
            default: begin
                decoded.illegal = 1'b1;
            end
        endcase
    end

    skid_buffer_2entry #(
        .WIDTH(BUNDLE_W)
    ) u_skid (
        .clock    (clock),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (decoded),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (presented)
    );

    assign out_a          = presented.a;
    assign out_a_negative = presented.a_neg;
    assign out_b          = presented.b;
    assign out_b_negative = presented.b_neg;
    assign out_illegal    = presented.illegal;

endmodule

// File: tb/tb_addsub_operand_stage.sv
// Directed bench for addsub_operand_stage at WORD_WIDTH=8. A small adder
// model turns the presented operands into a sum, compared against
// hand-computed results.
module tb_addsub_operand_stage;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_a;
    logic         out_a_negative;
    logic [W-1:0] out_b;
    logic         out_b_negative;
    logic         out_illegal;

    int compared = 0;
    int mismatched = 0;

    addsub_operand_stage #(.WORD_WIDTH(W)) dut (
        .clock         (clock),
        .clear         (clear),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_a          (in_a),
        .in_b          (in_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_a         (out_a),
        .out_a_negative(out_a_negative),
        .out_b         (out_b),
        .out_b_negative(out_b_negative),
        .out_illegal   (out_illegal)
    );

    always #5 clock = ~clock;

    // Model of the downstream ripple-carry adder/subtractor.
    function automatic logic [W-1:0] adder(input logic [W-1:0] a, input logic an,
                                           input logic [W-1:0] b, input logic bn);
        logic [W-1:0] ta;
        logic [W-1:0] tb;
        ta = an ? (~a + 8'd1) : a;
        tb = bn ? (~b + 8'd1) : b;
        return ta + tb;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
            $error("check %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] sum_now();
        return adder(out_a, out_a_negative, out_b, out_b_negative);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    logic [W-1:0] exp_sum [8];

    initial begin
        exp_sum[0] = 8'h08; exp_sum[1] = 8'h02; exp_sum[2] = 8'hFE; exp_sum[3] = 8'hF8;
        exp_sum[4] = 8'h05; exp_sum[5] = 8'hFB; exp_sum[6] = 8'h00; exp_sum[7] = 8'h00;

        // Reset then idle.
        clear = 1'b1; out_ready = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_illegal", 32'(out_illegal), 32'd0);
        check("rst_data", {14'd0, out_a, out_a_negative, out_b, out_b_negative}, 32'd0);
        clear = 1'b0;
        tick();
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Every opcode back to back, a=5 b=3, downstream always ready.
        out_ready = 1'b1;
        for (int op = 0; op < 8; op++) begin
            drive(1'b1, 3'(op), 8'd5, 8'd3);
            tick();
            check($sformatf("op%0d_valid", op), 32'(out_valid), 32'd1);
            check($sformatf("op%0d_sum", op), 32'(sum_now()), 32'(exp_sum[op]));
            check($sformatf("op%0d_illegal", op), 32'(out_illegal), (op >= 6) ? 32'd1 : 32'd0);
            if (op >= 6)
                check($sformatf("op%0d_zero", op),
                      {14'd0, out_a, out_a_negative, out_b, out_b_negative}, 32'd0);
        end
        drive(1'b0, 3'd0, 8'd0, 8'd0);
        tick();
        check("ops_drained", 32'(out_valid), 32'd0);

        // Back-pressure: four SUB ops (a-1) with the output stalled.
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 8'h11, 8'h01);
        tick();
        check("bp_ready_after1", 32'(in_ready), 32'd1);
        drive(1'b1, 3'd1, 8'h22, 8'h01);
        tick();
        check("bp_ready_full", 32'(in_ready), 32'd0);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_op1", 32'(sum_now()), 32'h10);
        drive(1'b1, 3'd1, 8'h33, 8'h01);
        tick(); tick();
        check("bp_still_full", 32'(in_ready), 32'd0);
        check("bp_still_op1", 32'(sum_now()), 32'h10);
        out_ready = 1'b1;
        tick();
        check("bp_out_op2", 32'(sum_now()), 32'h21);
        check("bp_ready_again", 32'(in_ready), 32'd1);
        tick();
        check("bp_out_op3", 32'(sum_now()), 32'h32);
        drive(1'b1, 3'd1, 8'h44, 8'h01);
        tick();
        check("bp_out_op4", 32'(sum_now()), 32'h43);
        drive(1'b0, 3'd0, 8'd0, 8'd0);
        tick();
        check("bp_no_dup", 32'(out_valid), 32'd0);

        // Wrap-around cases.
        drive(1'b1, 3'd5, 8'h80, 8'h00);
        tick();
        check("wrap_nega", 32'(sum_now()), 32'h80);
        drive(1'b1, 3'd0, 8'h7F, 8'h01);
        tick();
        check("wrap_add", 32'(sum_now()), 32'h80);
        drive(1'b0, 3'd0, 8'd0, 8'd0);
        tick();

        // Clear while FULL overrides accept and drain.
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 8'd9, 8'd9);
        tick(); tick();
        check("clr_pre_full", 32'(in_ready), 32'd0);
        clear = 1'b1; out_ready = 1'b1;
        drive(1'b1, 3'd0, 8'd3, 8'd3);
        tick();
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_in_ready", 32'(in_ready), 32'd1);
        check("clr_data", {14'd0, out_a, out_a_negative, out_b, out_b_negative}, 32'd0);
        clear = 1'b0;
        drive(1'b1, 3'd0, 8'd1, 8'd1);
        tick();
        check("clr_next_valid", 32'(out_valid), 32'd1);
        check("clr_next_sum", 32'(sum_now()), 32'd2);
        drive(1'b0, 3'd0, 8'd0, 8'd0);
        tick();
        check("clr_alone", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
